// File: rtl/control_x_pkg.sv
// Shared types and elaboration helpers for the X-vector ping-pong write controller.
package control_x_pkg;

   typedef enum logic [1:0] {
      W_IDLE  = 2'd0,
      W_FILL  = 2'd1,
      W_STALL = 2'd2
   } wstate_e;

   localparam int MIN_DATA_N    = 2;
   localparam int MIN_NUM_BANKS = 1;
   localparam int MAX_NUM_BANKS = 4;

   // Index width that never collapses to zero bits for tiny ranges.
   function automatic int safe_clog2(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic bit cfg_legal(input int data_n, input int num_banks);
      return (data_n >= MIN_DATA_N) &&
             (num_banks >= MIN_NUM_BANKS) &&
             (num_banks <= MAX_NUM_BANKS);
   endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up-counter with clear; wrap flags the increment that returns it to zero.
module mod_n_counter #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] value,
   output logic         wrap
);

   localparam logic [W-1:0] LAST_C = W'(N - 1);

   logic [W-1:0] value_r;

   assign wrap  = inc & (value_r == LAST_C);
   assign value = value_r;

   // Count register: clear has priority over increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         value_r <= {W{1'b0}};
      end else if (clr) begin
         value_r <= {W{1'b0}};
      end else if (inc) begin
         value_r <= wrap ? {W{1'b0}} : value_r + W'(1);
      end else begin
         value_r <= value_r;
      end
   end

endmodule

// File: rtl/control_x_pp.sv
// Multi-bank write controller for the convolution X-vector input buffers:
// streams words into NUM_BANKS banks while the engine drains full ones in order.
module control_x_pp
   import control_x_pkg::*;
#(
   parameter int DATA_N       = 8,
   parameter int LG_DATA_N    = safe_clog2(DATA_N),
   parameter int NUM_BANKS    = 2,
   parameter int LG_NUM_BANKS = safe_clog2(NUM_BANKS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_en,
   input  logic                    abort_x,
   input  logic                    s_valid_x,
   output logic                    s_ready_x,
   output logic [LG_DATA_N-1:0]    addr_x,
   output logic [LG_NUM_BANKS-1:0] wr_bank_x,
   output logic                    wr_en_x,
   output logic                    done_x,
   output logic                    rd_valid_x,
   output logic [LG_NUM_BANKS-1:0] rd_bank_x,
   input  logic                    rd_release_x,
   output logic [LG_NUM_BANKS:0]   full_count_x
);

   localparam int              FCW    = LG_NUM_BANKS + 1;
   localparam logic [FCW-1:0]  NB_C   = FCW'(NUM_BANKS);
   localparam logic            CFG_OK = cfg_legal(DATA_N, NUM_BANKS);

   wstate_e        state_r;
   wstate_e        state_s;
   logic [FCW-1:0] full_count_r;
   logic [FCW-1:0] full_next_s;
   logic           done_r;
   logic           ready_s;
   logic           wr_en_s;
   logic           last_beat_s;
   logic           rd_valid_s;
   logic           release_s;
   logic           wr_wrap_s;
   logic           rd_wrap_s;
   logic           unused_wrap_s;

   // An illegal configuration leaves the controller inert rather than corrupting banks.
   assign ready_s       = CFG_OK & load_en & ~abort_x & (full_count_r < NB_C);
   assign wr_en_s       = s_valid_x & ready_s;
   assign rd_valid_s    = (full_count_r != {FCW{1'b0}});
   assign release_s     = rd_release_x & rd_valid_s;
   assign unused_wrap_s = wr_wrap_s ^ rd_wrap_s;

   mod_n_counter #(.N(DATA_N), .W(LG_DATA_N)) u_addr (
      .clk   (clk),
      .reset (reset),
      .clr   (abort_x),
      .inc   (wr_en_s),
      .value (addr_x),
      .wrap  (last_beat_s)
   );

   mod_n_counter #(.N(NUM_BANKS), .W(LG_NUM_BANKS)) u_wr_bank (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (last_beat_s),
      .value (wr_bank_x),
      .wrap  (wr_wrap_s)
   );

   mod_n_counter #(.N(NUM_BANKS), .W(LG_NUM_BANKS)) u_rd_bank (
      .clk   (clk),
      .reset (reset),
      .clr   (1'b0),
      .inc   (release_s),
      .value (rd_bank_x),
      .wrap  (rd_wrap_s)
   );

   // Full-bank occupancy: a completion and a release in the same cycle cancel.
   always_comb begin
      full_next_s = full_count_r;
      case ({last_beat_s, release_s})
         2'b10:   full_next_s = full_count_r + FCW'(1);
         2'b01:   full_next_s = full_count_r - FCW'(1);
         default: full_next_s = full_count_r;
      endcase
   end

   // Write-side state tracking; looks at next occupancy so a same-cycle release is not missed.
   always_comb begin
      state_s = state_r;
      case (state_r)
         W_IDLE: begin
            if (abort_x) begin
               state_s = W_IDLE;
            end else if (full_next_s == NB_C) begin
               state_s = W_STALL;
            end else if (wr_en_s) begin
               state_s = W_FILL;
            end else begin
               state_s = W_IDLE;
            end
         end
         W_FILL: begin
            if (abort_x) begin
               state_s = W_IDLE;
            end else if (last_beat_s) begin
               state_s = (full_next_s == NB_C) ? W_STALL : W_IDLE;
            end else begin
               state_s = W_FILL;
            end
         end
         W_STALL: begin
            if (release_s) begin
               state_s = W_IDLE;
            end else begin
               state_s = W_STALL;
            end
         end
         default: state_s = W_IDLE;
      endcase
   end

   // Occupancy, completion pulse and FSM state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_count_r <= {FCW{1'b0}};
         done_r       <= 1'b0;
         state_r      <= W_IDLE;
      end else begin
         full_count_r <= full_next_s;
         done_r       <= last_beat_s;
         state_r      <= state_s;
      end
   end

   assign s_ready_x    = ready_s;
   assign wr_en_x      = wr_en_s;
   assign done_x       = done_r;
   assign rd_valid_x   = rd_valid_s;
   assign full_count_x = full_count_r;

endmodule
